fx1_result_pipe: RTL and testbench

- Fixed-latency result pipeline directly downstream of the FX1 simple-fixed-point ALU.
- Captures the ALU's combinational 128-bit result with its destination tag each cycle.
- Carries it through LATENCY register stages to the register-file write port.
- Exposes a three-way operand-forwarding lookup so the issue/operand-fetch stage can bypass in-flight FX1 results.

---
 rtl/fx1_result_pipe_pkg.sv | 73 +++++++
 rtl/fx1_result_pipe_fwd_lookup.sv | 25 ++
 rtl/fx1_result_pipe.sv | 103 ++++++++++
 tb/tb_fx1_result_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fx1_result_pipe_pkg.sv
// rtl/fx1_result_pipe_pkg.sv - opcode IDs, FX1 class predicate and result-stage record
package fx1_result_pipe_pkg;

  // Instruction-ID width shared with the issue logic
  localparam int ID_W = 7;

  // Result-stage field widths shared by the FX result pipes
  localparam int RES_DATA_W = 128;
  localparam int RES_ADDR_W = 7;

  // FX1 class: simple fixed-point ops, encoded contiguously from 0
  localparam logic [ID_W-1:0] instr_ID_A     = 7'd0;
  localparam logic [ID_W-1:0] instr_ID_AH    = 7'd1;
  localparam logic [ID_W-1:0] instr_ID_AI    = 7'd2;
  localparam logic [ID_W-1:0] instr_ID_AHI   = 7'd3;
  localparam logic [ID_W-1:0] instr_ID_SF    = 7'd4;
  localparam logic [ID_W-1:0] instr_ID_SFH   = 7'd5;
  localparam logic [ID_W-1:0] instr_ID_SFI   = 7'd6;
  localparam logic [ID_W-1:0] instr_ID_SFHI  = 7'd7;
  localparam logic [ID_W-1:0] instr_ID_ADDX  = 7'd8;
  localparam logic [ID_W-1:0] instr_ID_SFX   = 7'd9;
  localparam logic [ID_W-1:0] instr_ID_CG    = 7'd10;
  localparam logic [ID_W-1:0] instr_ID_BG    = 7'd11;
  localparam logic [ID_W-1:0] instr_ID_CGX   = 7'd12;
  localparam logic [ID_W-1:0] instr_ID_BGX   = 7'd13;
  localparam logic [ID_W-1:0] instr_ID_AND   = 7'd14;
  localparam logic [ID_W-1:0] instr_ID_ANDC  = 7'd15;
  localparam logic [ID_W-1:0] instr_ID_ANDBI = 7'd16;
  localparam logic [ID_W-1:0] instr_ID_ANDHI = 7'd17;
  localparam logic [ID_W-1:0] instr_ID_ANDI  = 7'd18;
  localparam logic [ID_W-1:0] instr_ID_OR    = 7'd19;
  localparam logic [ID_W-1:0] instr_ID_ORC   = 7'd20;
  localparam logic [ID_W-1:0] instr_ID_ORBI  = 7'd21;
  localparam logic [ID_W-1:0] instr_ID_ORHI  = 7'd22;
  localparam logic [ID_W-1:0] instr_ID_ORI   = 7'd23;
  localparam logic [ID_W-1:0] instr_ID_XOR   = 7'd24;
  localparam logic [ID_W-1:0] instr_ID_XORBI = 7'd25;
  localparam logic [ID_W-1:0] instr_ID_XORHI = 7'd26;
  localparam logic [ID_W-1:0] instr_ID_XORI  = 7'd27;
  localparam logic [ID_W-1:0] instr_ID_NAND  = 7'd28;
  localparam logic [ID_W-1:0] instr_ID_NOR   = 7'd29;
  localparam logic [ID_W-1:0] instr_ID_EQV   = 7'd30;
  localparam logic [ID_W-1:0] instr_ID_SELB  = 7'd31;
  localparam logic [ID_W-1:0] instr_ID_CEQ   = 7'd32;
  localparam logic [ID_W-1:0] instr_ID_CEQB  = 7'd33;
  localparam logic [ID_W-1:0] instr_ID_CEQH  = 7'd34;
  localparam logic [ID_W-1:0] instr_ID_CEQI  = 7'd35;
  localparam logic [ID_W-1:0] instr_ID_CGT   = 7'd36;
  localparam logic [ID_W-1:0] instr_ID_CGTB  = 7'd37;
  localparam logic [ID_W-1:0] instr_ID_CGTH  = 7'd38;
  localparam logic [ID_W-1:0] instr_ID_CLGT  = 7'd39;
  localparam logic [ID_W-1:0] instr_ID_CLGTB = 7'd40;

  // FX2 class (shift/rotate) starts right after the last FX1 encoding
  localparam logic [ID_W-1:0] instr_ID_SHLH  = 7'd41;
  localparam logic [ID_W-1:0] instr_ID_SHL   = 7'd42;
  localparam logic [ID_W-1:0] instr_ID_ROT   = 7'd43;
  localparam logic [ID_W-1:0] instr_ID_ROTH  = 7'd44;
  localparam logic [ID_W-1:0] instr_ID_SHLI  = 7'd45;

  // True for the 41 FX1-class IDs (contiguous block A..CLGTB)
  function automatic logic is_fx1_id(input logic [ID_W-1:0] id);
    return (id <= instr_ID_CLGTB);
  endfunction

  // One result-pipe stage; data bit 0 is the MSB
  typedef struct packed {
    logic                    valid;
    logic [RES_ADDR_W-1:0]   rt_addr;
    logic [0:RES_DATA_W-1]   data;
  } fx_stage_t;

endpackage

// File: rtl/fx1_result_pipe_fwd_lookup.sv
// rtl/fx1_result_pipe_fwd_lookup.sv - youngest-match forwarding mux over the result stages
module fx1_result_pipe_fwd_lookup
  import fx1_result_pipe_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  fx_stage_t               stages [LATENCY],
  input  logic [RES_ADDR_W-1:0]   query,
  output logic                    hit,
  output logic [0:RES_DATA_W-1]   data
);

  // Scan oldest to youngest so the lowest-index (youngest) match is the last writer
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      if (stages[k].valid && (stages[k].rt_addr == query)) begin
        hit  = 1'b1;
        data = stages[k].data;
      end
    end
  end

endmodule

// File: rtl/fx1_result_pipe.sv
// rtl/fx1_result_pipe.sv - FX1 fixed-latency result pipe with writeback and operand forwarding
module fx1_result_pipe #(
  parameter int LATENCY = 2,
  parameter int DATA_W  = fx1_result_pipe_pkg::RES_DATA_W,
  parameter int ADDR_W  = fx1_result_pipe_pkg::RES_ADDR_W,
  parameter int ID_W    = fx1_result_pipe_pkg::ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_instr_id,
  input  logic [ADDR_W-1:0] in_rt_addr,
  input  logic [0:DATA_W-1] in_result,
  input  logic              flush,
  input  logic [ADDR_W-1:0] fwd_ra_addr,
  input  logic [ADDR_W-1:0] fwd_rb_addr,
  input  logic [ADDR_W-1:0] fwd_rc_addr,
  output logic              fwd_ra_hit,
  output logic              fwd_rb_hit,
  output logic              fwd_rc_hit,
  output logic [0:DATA_W-1] fwd_ra_data,
  output logic [0:DATA_W-1] fwd_rb_data,
  output logic [0:DATA_W-1] fwd_rc_data,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rt_addr,
  output logic [0:DATA_W-1] wb_data,
  output logic              illegal_id,
  output logic              busy
);
  import fx1_result_pipe_pkg::*;

  // Stage widths come from the shared record; DATA_W/ADDR_W must match it.
  fx_stage_t stg [LATENCY];
  logic      id_is_fx1;
  logic      accept;
  logic      illegal_q;

  assign id_is_fx1 = is_fx1_id(in_instr_id);
  // A flush kills the instruction presented alongside it as well
  assign accept    = in_valid && !flush && id_is_fx1;

  // Advance the stages; youngest at index 0, flush clears every valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stg[k] <= '0;
      end
      illegal_q <= 1'b0;
    end else begin
      stg[0].valid <= accept;
      if (accept) begin
        stg[0].rt_addr <= in_rt_addr;
        stg[0].data    <= in_result;
      end
      for (int k = 1; k < LATENCY; k++) begin
        stg[k].valid   <= stg[k-1].valid && !flush;
        stg[k].rt_addr <= stg[k-1].rt_addr;
        stg[k].data    <= stg[k-1].data;
      end
      // Dropped non-FX1 issue is reported one cycle later; a flushed one is not
      illegal_q <= in_valid && !flush && !id_is_fx1;
    end
  end

  // Oldest stage drives the register-file write port
  always_comb begin
    wb_valid   = stg[LATENCY-1].valid;
    wb_rt_addr = stg[LATENCY-1].rt_addr;
    wb_data    = stg[LATENCY-1].data;
  end

  // Pipe is busy while any stage holds a live result
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | stg[k].valid;
    end
  end

  assign illegal_id = illegal_q;

  fx1_result_pipe_fwd_lookup #(.LATENCY(LATENCY)) u_fwd_ra (
    .stages (stg),
    .query  (fwd_ra_addr),
    .hit    (fwd_ra_hit),
    .data   (fwd_ra_data)
  );

  fx1_result_pipe_fwd_lookup #(.LATENCY(LATENCY)) u_fwd_rb (
    .stages (stg),
    .query  (fwd_rb_addr),
    .hit    (fwd_rb_hit),
    .data   (fwd_rb_data)
  );

  fx1_result_pipe_fwd_lookup #(.LATENCY(LATENCY)) u_fwd_rc (
    .stages (stg),
    .query  (fwd_rc_addr),
    .hit    (fwd_rc_hit),
    .data   (fwd_rc_data)
  );

endmodule

// File: tb/tb_fx1_result_pipe.sv
// tb/tb_fx1_result_pipe.sv - scoreboard bench for fx1_result_pipe
module tb_fx1_result_pipe;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [6:0]   in_instr_id = '0;
  logic [6:0]   in_rt_addr = '0;
  logic [0:127] in_result = '0;
  logic         flush = 1'b0;
  logic [6:0]   fwd_ra_addr = '0, fwd_rb_addr = '0, fwd_rc_addr = '0;
  logic         fwd_ra_hit, fwd_rb_hit, fwd_rc_hit;
  logic [0:127] fwd_ra_data, fwd_rb_data, fwd_rc_data;
  logic         wb_valid;
  logic [6:0]   wb_rt_addr;
  logic [0:127] wb_data;
  logic         illegal_id, busy;

  always #5 clk = ~clk;

  fx1_result_pipe #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr_id(in_instr_id),
    .in_rt_addr(in_rt_addr), .in_result(in_result), .flush(flush),
    .fwd_ra_addr(fwd_ra_addr), .fwd_rb_addr(fwd_rb_addr), .fwd_rc_addr(fwd_rc_addr),
    .fwd_ra_hit(fwd_ra_hit), .fwd_rb_hit(fwd_rb_hit), .fwd_rc_hit(fwd_rc_hit),
    .fwd_ra_data(fwd_ra_data), .fwd_rb_data(fwd_rb_data), .fwd_rc_data(fwd_rc_data),
    .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .wb_data(wb_data),
    .illegal_id(illegal_id), .busy(busy)
  );

  // Expected writebacks: the cycle (edge count) in which each appears on wb_*
  typedef struct {
    int           due;
    logic [6:0]   rt;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  bit   ill [0:8191];
  int   edges = 0;
  int   last_rst_edge = -1;
  int   total = 0;
  int   bad = 0;
  bit   pend_kill = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  function automatic void chk(input string n, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", n, edges, act, req);
    end
  endfunction

  // An entry is in flight from the cycle after its issue edge through its due cycle
  function automatic void fwd_model(input logic [6:0] a, input int c,
                                    output logic h, output logic [127:0] d);
    h = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if ((q[i].due - LAT + 1 <= c) && (q[i].rt == a)) begin
        h = 1'b1;
        d = q[i].data;
      end
    end
  endfunction

  function automatic logic busy_model(input int c);
    foreach (q[i]) if (q[i].due - LAT + 1 <= c) return 1'b1;
    return 1'b0;
  endfunction

  logic         m_h;
  logic [127:0] m_d;

  // Monitor: compares every output mid-cycle against the scoreboard
  always @(negedge clk) begin
    fwd_model(fwd_ra_addr, edges, m_h, m_d);
    chk("ra_hit", fwd_ra_hit, m_h);  chk("ra_data", fwd_ra_data, m_d);
    fwd_model(fwd_rb_addr, edges, m_h, m_d);
    chk("rb_hit", fwd_rb_hit, m_h);  chk("rb_data", fwd_rb_data, m_d);
    fwd_model(fwd_rc_addr, edges, m_h, m_d);
    chk("rc_hit", fwd_rc_hit, m_h);  chk("rc_data", fwd_rc_data, m_d);
    chk("busy", busy, busy_model(edges));
    chk("illegal_id", illegal_id, ill[edges]);
    if (edges == last_rst_edge) begin
      chk("rst_wb_rt", wb_rt_addr, 0);
      chk("rst_wb_data", wb_data, 0);
    end
    while (q.size() > 0 && q[0].due < edges) begin
      total++;
      bad++;
      $display("FAIL wb_missed rt=%0d due=%0d actual=none required=write", q[0].rt, q[0].due);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == edges) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_rt", wb_rt_addr, q[0].rt);
      chk("wb_data", wb_data, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("wb_idle", wb_valid, 0);
    end
  end

  // Drive one cycle of inputs (sampled at the next edge) and update the scoreboard
  task automatic step(input logic v, input logic [6:0] id, input logic [6:0] rt,
                      input logic [127:0] d, input logic fl, input logic r,
                      input logic [6:0] qa, input logic [6:0] qb, input logic [6:0] qc);
    int   e;
    exp_t x;
    @(posedge clk);
    #1;
    if (pend_kill) begin
      while (q.size() > 0 && q[q.size()-1].due >= edges) void'(q.pop_back());
      pend_kill = 1'b0;
    end
    e = edges + 1;
    rst = r; flush = fl; in_valid = v; in_instr_id = id; in_rt_addr = rt; in_result = d;
    fwd_ra_addr = qa; fwd_rb_addr = qb; fwd_rc_addr = qc;
    if (r || fl) begin
      pend_kill = 1'b1;
      if (r) last_rst_edge = e;
    end else if (v && id < 7'd41) begin
      x.due = e + LAT - 1; x.rt = rt; x.data = d;
      q.push_back(x);
    end else if (v) begin
      ill[e] = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [6:0] qa, input logic [6:0] qb, input logic [6:0] qc);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, qa, qb, qc);
  endtask

  logic         rv, rfl, rrs;
  logic [6:0]   rid, rrt;
  logic [127:0] rdat;
  int           roll;

  initial begin
    step(0, 0, 0, '0, 0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0, 0);
    idle(2, 5, 0, 0);
    // single instruction, rt=5
    step(1, 7'd0, 7'd5, 128'h0123456789abcdef0123456789abcdef, 0, 0, 5, 5, 5);
    idle(4, 5, 5, 5);
    // same rt back to back
    step(1, 7'd1, 7'd9, {16{8'h11}}, 0, 0, 9, 0, 0);
    step(1, 7'd2, 7'd9, {16{8'h22}}, 0, 0, 9, 0, 0);
    idle(4, 9, 9, 0);
    // three-way query: S1 rt=4, S2 rt=3
    step(1, 7'd3, 7'd3, {4{32'h33333333}}, 0, 0, 0, 0, 0);
    step(1, 7'd4, 7'd4, {4{32'h44444444}}, 0, 0, 0, 0, 0);
    idle(3, 3, 4, 7);
    // flush while rt=3 is presented
    step(1, 7'd14, 7'd1, {4{32'h01010101}}, 0, 0, 1, 2, 3);
    step(1, 7'd19, 7'd2, {4{32'h02020202}}, 0, 0, 1, 2, 3);
    step(1, 7'd24, 7'd3, {4{32'h03030303}}, 1, 0, 1, 2, 3);
    idle(4, 1, 2, 3);
    // non-FX1 ID is dropped and flagged
    step(1, 7'd45, 7'd6, {4{32'h66666666}}, 0, 0, 6, 6, 6);
    idle(4, 6, 6, 6);
    // register 0 forwarded and written
    step(1, 7'd40, 7'd0, {4{32'h0000ffff}}, 0, 0, 0, 0, 0);
    idle(3, 0, 0, 0);
    // reset with two in flight
    step(1, 7'd5, 7'd10, {4{32'haaaaaaaa}}, 0, 0, 10, 11, 0);
    step(1, 7'd6, 7'd11, {4{32'hbbbbbbbb}}, 0, 0, 10, 11, 0);
    step(0, 7'd0, 7'd0, '0, 0, 1, 10, 11, 0);
    idle(4, 10, 11, 0);
    // randomized traffic on a small register window to provoke hits
    for (int i = 0; i < 600; i++) begin
      roll = $urandom_range(0, 99);
      rfl  = (roll < 5);
      rrs  = (roll >= 5 && roll < 7);
      rv   = ($urandom_range(0, 99) < 65);
      if (rfl || $urandom_range(0, 99) < 85) rid = 7'($urandom_range(0, 40));
      else rid = 7'($urandom_range(41, 127));
      rrt  = 7'($urandom_range(0, 7));
      rdat = {$urandom, $urandom, $urandom, $urandom};
      step(rv, rid, rrt, rdat, rfl, rrs,
           7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
    end
    idle(LAT + 3, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
